// File: rtl/comp_pkg.sv
// Shared definitions for the serial comparator family.
// Latency: none (package only).
// Backpressure: not applicable.
// Contents: FSM state encodings, slice-count and count-width helpers.
package comp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of 2-bit slices in an operand of the given width.
   function automatic int n_slices(input int width);
      return width / 2;
   endfunction

   // Bits needed to hold a slice count from 0 to n_slices(width) inclusive.
   function automatic int cnt_width(input int width);
      return (width / 2 < 1) ? 1 : $clog2(width / 2 + 1);
   endfunction

endpackage

// File: rtl/comp_2bit.sv
// 2-bit magnitude comparator built from 2:1 muxes.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (2-bit operands); l = a<b, e = a==b, g = a>b (exactly one high).
module comp_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       l,
   output logic       e,
   output logic       g
);

   logic msb_diff;

   assign msb_diff = a[1] ^ b[1];

   // When the MSBs differ they alone decide; otherwise the LSBs decide.
   assign l = msb_diff ? b[1] : (~a[0] & b[0]);
   assign g = msb_diff ? a[1] : (a[0] & ~b[0]);
   assign e = ~(l | g);

endmodule

// File: rtl/serial_mag_comp.sv
// Sequential magnitude comparator: two bits per cycle, MSB first, one-hot lt/eq/gt.
// Latency: 1..N cycles after accept (first differing slice with EARLY_EXIT, else N).
// Backpressure: result held in DONE until res_ready; no new operands accepted until back in IDLE.
// Ports: clk, rst (sync, active high); start_valid/start_ready with a_in/b_in;
//        res_valid/res_ready with lt/eq/gt and slices_used (slices evaluated).
module serial_mag_comp
   import comp_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  bit EARLY_EXIT = 1'b1,
   localparam int N          = n_slices(WIDTH),
   localparam int SW         = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [SW-1:0]    slices_used
);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
         $error("serial_mag_comp: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t           state_q, state_d, cur;
   logic [WIDTH-1:0] a_sh, a_sh_d;
   logic [WIDTH-1:0] b_sh, b_sh_d;
   logic [SW-1:0]    cnt, cnt_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

   logic sl_l, sl_e, sl_g;
   logic decided, first_diff;

   comp_2bit u_slice (
      .a (a_sh[WIDTH-1 -: 2]),
      .b (b_sh[WIDTH-1 -: 2]),
      .l (sl_l),
      .e (sl_e),
      .g (sl_g)
   );

   // Unused encoding 2'd3 behaves exactly as IDLE.
   assign cur = (state_q inside {ST_IDLE, ST_RUN, ST_DONE}) ? state_q : ST_IDLE;

   // A difference is already recorded once lt or gt is set; later slices never override it.
   assign decided    = lt_q | gt_q;
   assign first_diff = ~decided & ~sl_e;

   always_comb begin
      state_d = cur;
      a_sh_d  = a_sh;
      b_sh_d  = b_sh;
      cnt_d   = cnt;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;

      case (cur)
         ST_IDLE: begin
            if (start_valid) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               cnt_d   = '0;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d  = cnt + 1'b1;
            a_sh_d = a_sh << 2;
            b_sh_d = b_sh << 2;
            if (first_diff) begin
               lt_d = sl_l;
               gt_d = sl_g;
            end
            if ((EARLY_EXIT && first_diff) || (cnt_d == SW'(N))) begin
               eq_d    = ~(lt_d | gt_d);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         cnt     <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh    <= a_sh_d;
         b_sh    <= b_sh_d;
         cnt     <= cnt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   // The slice counter doubles as the reported slice count: it only advances in RUN.
   assign start_ready = (cur == ST_IDLE);
   assign res_valid   = (cur == ST_DONE);
   assign lt          = lt_q;
   assign eq          = eq_q;
   assign gt          = gt_q;
   assign slices_used = cnt;

endmodule
